// File: rtl/input_event_conditioner.sv
// Multi-channel pin conditioner: synchroniser, polarity normalisation, debounce,
// selectable edge events, retriggerable pulse stretcher, sticky flag and saturating counter.
module input_event_conditioner #(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int TIMEOUT       = 50000,
  parameter int TIMEOUT_WIDTH = 16,
  parameter int ACTIVE_LOW    = 1,
  parameter int PULSE_EXT     = 1,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [CHANNELS-1:0]           data_in,
  input  logic [2*CHANNELS-1:0]         edge_mode,
  input  logic [CHANNELS-1:0]           event_clr,
  input  logic                          count_clr,
  output logic [CHANNELS-1:0]           level_out,
  output logic [CHANNELS-1:0]           pulse_out,
  output logic [CHANNELS-1:0]           event_sticky,
  output logic [CHANNELS*CNT_WIDTH-1:0] event_count
);

  localparam int                     PULSE_WIDTH = $clog2(PULSE_EXT + 1);
  localparam logic                   IDLE_PIN    = (ACTIVE_LOW != 0);
  localparam logic [TIMEOUT_WIDTH-1:0] DB_LAST   = TIMEOUT_WIDTH'(TIMEOUT - 1);
  localparam logic [PULSE_WIDTH-1:0] PULSE_LOAD  = PULSE_WIDTH'(PULSE_EXT);
  localparam logic [CNT_WIDTH-1:0]   CNT_MAX     = '1;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     sample;
    logic                     level_q;
    logic                     toggled;
    logic                     evt;
    logic [1:0]               mode;
    logic [TIMEOUT_WIDTH-1:0] db_cnt;
    logic [PULSE_WIDTH-1:0]   pulse_cnt;
    logic                     sticky_q;
    logic [CNT_WIDTH-1:0]     evt_cnt;

    assign mode   = edge_mode[2*i +: 2];
    assign sample = sync_q[SYNC_STAGES-1] ^ IDLE_PIN;

    // The synchroniser resets to the idle pin level so leaving reset never
    // looks like a fresh assertion.
    always_ff @(posedge clk) begin
      // NOTE: all state uses non-blocking assignments so every register samples
      // pre-edge values regardless of statement order.
      if (reset) sync_q <= {SYNC_STAGES{IDLE_PIN}};
      else       sync_q <= {sync_q[SYNC_STAGES-2:0], data_in[i]};
    end

    // toggled marks the cycle right after level_q changed; the event is
    // qualified there so it sees the new level and the current edge_mode.
    always_ff @(posedge clk) begin
      if (reset) begin
        level_q <= 1'b0;
        db_cnt  <= '0;
        toggled <= 1'b0;
      end else begin
        toggled <= 1'b0;
        if (sample != level_q) begin
          if (db_cnt == DB_LAST) begin
            level_q <= ~level_q;
            db_cnt  <= '0;
            toggled <= 1'b1;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end else begin
          db_cnt <= '0;
        end
      end
    end

    assign evt = toggled & (level_q ? mode[0] : mode[1]);

    always_ff @(posedge clk) begin
      if (reset)                  pulse_cnt <= '0;
      else if (evt)               pulse_cnt <= PULSE_LOAD;
      else if (pulse_cnt != '0)   pulse_cnt <= pulse_cnt - 1'b1;
    end

    // Set has priority over clear so a coincident event is never lost.
    always_ff @(posedge clk) begin
      if (reset)             sticky_q <= 1'b0;
      else if (evt)          sticky_q <= 1'b1;
      else if (event_clr[i]) sticky_q <= 1'b0;
    end

    always_ff @(posedge clk) begin
      if (reset)                          evt_cnt <= '0;
      else if (count_clr)                 evt_cnt <= evt ? CNT_WIDTH'(1) : '0;
      else if (evt && evt_cnt != CNT_MAX) evt_cnt <= evt_cnt + 1'b1;
    end

    assign level_out[i]                         = level_q;
    assign pulse_out[i]                         = (pulse_cnt != '0);
    assign event_sticky[i]                      = sticky_q;
    assign event_count[i*CNT_WIDTH +: CNT_WIDTH] = evt_cnt;
  end

endmodule

// File: tb/tb_input_event_conditioner.sv
// Scoreboard bench: two conditioner instances (short and long pulse) share stimulus
// and are compared every cycle against a timestamp-based reference model.
module tb_input_event_conditioner;

  localparam int CH  = 2;
  localparam int SS  = 2;
  localparam int TO  = 8;
  localparam int TW  = 4;
  localparam int CW  = 4;
  localparam int PA  = 3;
  localparam int PB  = 12;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset     = 1'b1;
  logic [CH-1:0]     data_in   = '1;
  logic [2*CH-1:0]   edge_mode = 4'b1101;
  logic [CH-1:0]     event_clr = '0;
  logic              count_clr = 1'b0;

  logic [CH-1:0]     level_a, pulse_a, sticky_a, level_b, pulse_b, sticky_b;
  logic [CH*CW-1:0]  count_a, count_b;

  input_event_conditioner #(
    .CHANNELS(CH), .SYNC_STAGES(SS), .TIMEOUT(TO), .TIMEOUT_WIDTH(TW),
    .ACTIVE_LOW(1), .PULSE_EXT(PA), .CNT_WIDTH(CW)
  ) dut_a (
    .clk(clk), .reset(reset), .data_in(data_in), .edge_mode(edge_mode),
    .event_clr(event_clr), .count_clr(count_clr), .level_out(level_a),
    .pulse_out(pulse_a), .event_sticky(sticky_a), .event_count(count_a)
  );

  input_event_conditioner #(
    .CHANNELS(CH), .SYNC_STAGES(SS), .TIMEOUT(TO), .TIMEOUT_WIDTH(TW),
    .ACTIVE_LOW(1), .PULSE_EXT(PB), .CNT_WIDTH(CW)
  ) dut_b (
    .clk(clk), .reset(reset), .data_in(data_in), .edge_mode(edge_mode),
    .event_clr(event_clr), .count_clr(count_clr), .level_out(level_b),
    .pulse_out(pulse_b), .event_sticky(sticky_b), .event_count(count_b)
  );

  typedef struct {
    int               edge_id;
    logic [CH-1:0]    level;
    logic [CH-1:0]    pulse_a;
    logic [CH-1:0]    pulse_b;
    logic [CH-1:0]    sticky;
    logic [CH*CW-1:0] count;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: the pin seen SS edges late, a run length of
  // disagreeing samples, and pulse end times instead of down-counters.
  logic [CH-1:0] pin_q[$];
  bit m_lvl[CH];
  int m_run[CH];
  bit m_pend[CH];
  int m_end_a[CH];
  int m_end_b[CH];
  bit m_sticky[CH];
  int m_cnt[CH];
  int edge_no = 0;

  function automatic void model_reset();
    pin_q.delete();
    for (int k = 0; k < SS; k++) pin_q.push_back('1);
    for (int c = 0; c < CH; c++) begin
      m_lvl[c] = 0; m_run[c] = 0; m_pend[c] = 0;
      m_end_a[c] = -1; m_end_b[c] = -1; m_sticky[c] = 0; m_cnt[c] = 0;
    end
  endfunction

  function automatic void model_edge();
    exp_t e;
    edge_no++;
    if (reset) begin
      model_reset();
    end else begin
      logic [CH-1:0] s;
      s = ~pin_q.pop_front();
      pin_q.push_back(data_in);
      for (int c = 0; c < CH; c++) begin
        bit evt;
        evt = m_pend[c] && (m_lvl[c] ? edge_mode[2*c] : edge_mode[2*c+1]);
        if (evt) begin
          m_end_a[c]  = edge_no + PA - 1;
          m_end_b[c]  = edge_no + PB - 1;
          m_sticky[c] = 1;
        end else if (event_clr[c]) begin
          m_sticky[c] = 0;
        end
        if (count_clr)               m_cnt[c] = evt ? 1 : 0;
        else if (evt && m_cnt[c] < MAXC) m_cnt[c] = m_cnt[c] + 1;
        m_pend[c] = 0;
        if (s[c] != m_lvl[c]) begin
          m_run[c] = m_run[c] + 1;
          if (m_run[c] == TO) begin
            m_lvl[c] = !m_lvl[c]; m_run[c] = 0; m_pend[c] = 1;
          end
        end else begin
          m_run[c] = 0;
        end
      end
    end
    e.edge_id = edge_no;
    for (int c = 0; c < CH; c++) begin
      e.level[c]           = m_lvl[c];
      e.pulse_a[c]         = (edge_no <= m_end_a[c]);
      e.pulse_b[c]         = (edge_no <= m_end_b[c]);
      e.sticky[c]          = m_sticky[c];
      e.count[c*CW +: CW]  = CW'(m_cnt[c]);
    end
    exp_q.push_back(e);
  endfunction

  // Monitor: every edge produces one output set to compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("level_a@%0d", e.edge_id),  level_a,  e.level);
        check($sformatf("level_b@%0d", e.edge_id),  level_b,  e.level);
        check($sformatf("pulse_a@%0d", e.edge_id),  pulse_a,  e.pulse_a);
        check($sformatf("pulse_b@%0d", e.edge_id),  pulse_b,  e.pulse_b);
        check($sformatf("sticky_a@%0d", e.edge_id), sticky_a, e.sticky);
        check($sformatf("sticky_b@%0d", e.edge_id), sticky_b, e.sticky);
        check($sformatf("count_a@%0d", e.edge_id),  count_a,  e.count);
        check($sformatf("count_b@%0d", e.edge_id),  count_b,  e.count);
      end
    end
  end

  // One clock: predict the upcoming edge, let it happen, drop one-shot inputs.
  task automatic step(int n = 1);
    for (int k = 0; k < n; k++) begin
      model_edge();
      @(posedge clk);
      #2;
      event_clr = '0;
      count_clr = 1'b0;
    end
  endtask

  // Advance until the model says an event is evaluated on the next edge.
  task automatic run_until_evt(int ch);
    int k = 0;
    while (!m_pend[ch] && k < 40) begin
      step();
      k++;
    end
    if (!m_pend[ch]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL evt_wait ch%0d: no event within 40 cycles", ch);
    end
  endtask

  function automatic logic [CW-1:0] cnt_of(logic [CH*CW-1:0] v, int ch);
    return v[ch*CW +: CW];
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, hi, run, best;
    model_reset();

    // Reset, then a press on ch0 (rising mode).
    step(3);
    reset = 1'b0;
    step(5);

    data_in[0] = 1'b0;
    n = 0;
    while (n < 30) begin
      step();
      n++;
      if (level_a[0] === 1'b1) break;
    end
    check("press_latency", n, SS + TO);
    hi = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (pulse_a[0] === 1'b1) hi++;
    end
    check("pulse_width", hi, PA);
    check("press_sticky", sticky_a[0], 1);
    check("press_count", cnt_of(count_a, 0), 1);
    data_in[0] = 1'b1;
    step(20);

    // Glitches: 7 low cycles rejected, 8 accepted.
    data_in[0] = 1'b0; step(7);
    data_in[0] = 1'b1; step(20);
    check("glitch7_level", level_a[0], 0);
    check("glitch7_count", cnt_of(count_a, 0), 1);
    data_in[0] = 1'b0; step(8);
    data_in[0] = 1'b1; step(20);
    check("glitch8_count", cnt_of(count_a, 0), 2);

    // ch1 edge modes: both, falling only, off.
    data_in[1] = 1'b0; step(20);
    data_in[1] = 1'b1; step(20);
    check("mode11_count", cnt_of(count_a, 1), 2);
    edge_mode[3:2] = 2'b10;
    data_in[1] = 1'b0; step(20);
    data_in[1] = 1'b1; step(20);
    check("mode10_count", cnt_of(count_a, 1), 3);
    edge_mode[3:2] = 2'b00;
    data_in[1] = 1'b0; step(20);
    check("mode00_level", level_a[1], 1);
    data_in[1] = 1'b1; step(20);
    check("mode00_count", cnt_of(count_a, 1), 3);
    edge_mode[3:2] = 2'b11;

    // Saturation, then count_clr coincident with an event.
    for (int k = 0; k < 17; k++) begin
      data_in[0] = 1'b0; step(12);
      data_in[0] = 1'b1; step(12);
    end
    check("sat_count", cnt_of(count_a, 0), MAXC);
    data_in[0] = 1'b0;
    run_until_evt(0);
    count_clr = 1'b1;
    step();
    check("clr_evt_count0", cnt_of(count_a, 0), 1);
    check("clr_evt_count1", cnt_of(count_a, 1), 0);
    data_in[0] = 1'b1; step(12);

    // Sticky race: clear coincident with event keeps it, next clear drops it.
    event_clr = 2'b01; step();
    data_in[0] = 1'b0;
    run_until_evt(0);
    event_clr[0] = 1'b1; step();
    check("sticky_race_set", sticky_a[0], 1);
    event_clr[0] = 1'b1; step();
    check("sticky_later_clr", sticky_a[0], 0);
    data_in[0] = 1'b1; step(12);

    // Retrigger on the long-pulse instance: events 9 cycles apart.
    run = 0; best = 0;
    data_in[1] = 1'b0;
    for (int k = 0; k < 45; k++) begin
      if (k == 9) data_in[1] = 1'b1;
      step();
      if (pulse_b[1] === 1'b1) begin
        run++;
        if (run > best) best = run;
      end else begin
        run = 0;
      end
    end
    check("retrigger_span", best, 9 + PB);

    // Reset in the middle of a pulse, input kept asserted.
    data_in[0] = 1'b0;
    run_until_evt(0);
    step(2);
    reset = 1'b1; step();
    check("rst_level", {level_a, level_b}, 0);
    check("rst_pulse", {pulse_a, pulse_b}, 0);
    check("rst_sticky", {sticky_a, sticky_b}, 0);
    check("rst_count", {count_a, count_b}, 0);
    reset = 1'b0;
    n = 0;
    while (n < 30) begin
      step();
      n++;
      if (level_b[0] === 1'b1) break;
    end
    check("post_rst_latency", n, SS + TO);

    // Random traffic.
    for (int k = 0; k < 2000; k++) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(11) == 0) data_in[c] = ~data_in[c];
      if ($urandom_range(60) == 0) edge_mode = 4'($urandom);
      event_clr = ($urandom_range(7) == 0) ? CH'($urandom) : '0;
      count_clr = ($urandom_range(39) == 0);
      reset     = ($urandom_range(399) == 0);
      step();
      reset = 1'b0;
    end
    data_in = '1;
    step(30);

    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
